// File: rtl/ysyx_25030077_ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// The bus response code for a good read lives here.
package ysyx_25030077_ifq_pkg;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } ifq_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_25030077_fifo.sv
// Parametrised circular FIFO with wrapping pointers, an occupancy count and a one-cycle flush.
// The head entry is always visible; push and pop are never checked against full/empty here.
module ysyx_25030077_fifo
  import ysyx_25030077_ifq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Explicit wrap keeps a 1-entry FIFO (1-bit pointer) pinned at index 0.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_25030077_ifq.sv
// Instruction-fetch queue: buffers fetch addresses, issues bus ARs with a cap on reads in
// flight, tags in-order R beats with their address, and discards beats orphaned by a flush.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_NORMAL | no stale reads pending; R beats are forwarded as responses
//   ST_DRAIN  | stale > 0; R beats are accepted and silently dropped
module ysyx_25030077_ifq
  import ysyx_25030077_ifq_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_rd_Req_valid,
  output logic                   io_rd_Req_ready,
  input  logic [ADDR_W-1:0]      io_rd_Req_bits_addr,
  output logic                   io_ar_valid,
  input  logic                   io_ar_ready,
  output logic [ADDR_W-1:0]      io_ar_bits_addr,
  input  logic                   io_r_valid,
  output logic                   io_r_ready,
  input  logic [DATA_W-1:0]      io_r_bits_data,
  input  logic [1:0]             io_r_bits_resp,
  output logic                   io_rsp_valid,
  input  logic                   io_rsp_ready,
  output logic [ADDR_W-1:0]      io_rsp_bits_addr,
  output logic [DATA_W-1:0]      io_rsp_bits_inst,
  output logic                   io_rsp_bits_err,
  input  logic                   io_flush,
  output logic [$clog2(DEPTH):0] io_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  ifq_state_t        state;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] q_head;
  logic [OUT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] inflight_head;
  logic [OUT_W-1:0]  stale;
  logic [OUT_W-1:0]  stale_nxt;
  logic              draining;
  logic              enq;
  logic              ar_fire;
  logic              r_fire;

  assign draining = (state == ST_DRAIN);

  // Every handshake output is gated by reset so the ports read idle before the first edge.
  assign io_rd_Req_ready  = reset && (q_count < CNT_W'(DEPTH));
  assign io_ar_valid      = reset && (q_count != '0) && (outstanding < OUT_W'(MAX_OUT)) && !io_flush;
  assign io_ar_bits_addr  = q_head;
  assign io_r_ready       = reset && (draining || io_rsp_ready);
  assign io_rsp_valid     = reset && io_r_valid && !draining && !io_flush;
  assign io_rsp_bits_addr = inflight_head;
  assign io_rsp_bits_inst = io_r_bits_data;
  assign io_rsp_bits_err  = (io_r_bits_resp != RESP_OKAY);
  assign io_count         = reset ? q_count : '0;

  assign enq     = io_rd_Req_valid && io_rd_Req_ready && !io_flush;
  assign ar_fire = io_ar_valid && io_ar_ready;
  assign r_fire  = io_r_valid && io_r_ready;

  ysyx_25030077_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_req_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_flush),
    .push      (enq),
    .push_data (io_rd_Req_bits_addr),
    .pop       (ar_fire),
    .head      (q_head),
    .count     (q_count)
  );

  // Never flushed: stale beats still have to retire their in-flight entries in order.
  ysyx_25030077_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_inflight_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (ar_fire),
    .push_data (q_head),
    .pop       (r_fire),
    .head      (inflight_head),
    .count     (outstanding)
  );

  always_comb begin
    stale_nxt = stale;
    if (io_flush)
      stale_nxt = outstanding - OUT_W'(r_fire);
    else if (draining && r_fire)
      stale_nxt = stale - OUT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_NORMAL;
      stale <= '0;
    end else begin
      stale <= stale_nxt;
      case (state)
        ST_NORMAL: state <= (stale_nxt != '0) ? ST_DRAIN : ST_NORMAL;
        ST_DRAIN:  state <= (stale_nxt == '0) ? ST_NORMAL : ST_DRAIN;
        default:   state <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030077_ifq.sv
// Scoreboard bench for the fetch queue: a queue-based reference model tracks requests,
// bus reads in flight and stale beats; a negedge monitor compares every DUT output.
module tb_ysyx_25030077_ifq;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          ar_valid;
  logic          ar_ready = 1'b0;
  logic [AW-1:0] ar_addr;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [DW-1:0] r_data = '0;
  logic [1:0]    r_resp = 2'b00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_inst;
  logic          rsp_err;
  logic          flush = 1'b0;
  logic [2:0]    count;

  int n_chk = 0;
  int n_fail = 0;

  logic [AW-1:0] refq [$];
  logic [AW-1:0] infl [$];
  int stale = 0;
  int n_rsp = 0;
  int n_disc = 0;

  always #5 clock = ~clock;

  ysyx_25030077_ifq #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_rd_Req_valid     (rd_valid),
    .io_rd_Req_ready     (rd_ready),
    .io_rd_Req_bits_addr (rd_addr),
    .io_ar_valid         (ar_valid),
    .io_ar_ready         (ar_ready),
    .io_ar_bits_addr     (ar_addr),
    .io_r_valid          (r_valid),
    .io_r_ready          (r_ready),
    .io_r_bits_data      (r_data),
    .io_r_bits_resp      (r_resp),
    .io_rsp_valid        (rsp_valid),
    .io_rsp_ready        (rsp_ready),
    .io_rsp_bits_addr    (rsp_addr),
    .io_rsp_bits_inst    (rsp_inst),
    .io_rsp_bits_err     (rsp_err),
    .io_flush            (flush),
    .io_count            (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model: inputs are stable from posedge+1 until the next posedge.
  logic e_rdy, e_arv, e_rr, e_rv, m_enq, m_ar, m_r;
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_r_ready", r_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_count", count, 0);
      refq.delete();
      infl.delete();
      stale = 0;
    end else begin
      e_rdy = refq.size() < DEPTH;
      e_arv = refq.size() != 0 && infl.size() < MAX_OUT && !flush;
      e_rr  = (stale > 0) ? 1'b1 : rsp_ready;
      e_rv  = r_valid && stale == 0 && !flush;
      chk("rd_ready", rd_ready, e_rdy);
      chk("count", count, refq.size());
      chk("ar_valid", ar_valid, e_arv);
      chk("r_ready", r_ready, e_rr);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_arv) chk("ar_addr", ar_addr, refq[0]);
      if (e_rv && infl.size() > 0) begin
        chk("rsp_addr", rsp_addr, infl[0]);
        chk("rsp_inst", rsp_inst, r_data);
        chk("rsp_err", rsp_err, r_resp != 2'b00);
      end
      m_enq = rd_valid && e_rdy && !flush;
      m_ar  = e_arv && ar_ready;
      m_r   = r_valid && e_rr && infl.size() > 0;
      if (m_r) begin
        if (e_rv) n_rsp++;
        else n_disc++;
        void'(infl.pop_front());
      end
      if (m_ar) infl.push_back(refq.pop_front());
      if (flush) begin
        stale = infl.size();
        refq.delete();
      end else if (m_r && stale > 0) begin
        stale--;
      end
      if (m_enq) refq.push_back(rd_addr);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_one(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] rs);
    int n;
    rd_valid = 1; rd_addr = a; ar_ready = 1; rsp_ready = 1; r_valid = 0;
    tick();
    rd_valid = 0;
    n = 0;
    while (infl.size() == 0 && n < 20) begin tick(); n++; end
    chk("fetch_ar_timeout", n < 20, 1);
    r_valid = 1; r_data = d; r_resp = rs;
    #1;
    chk("fetch_rsp_valid", rsp_valid, 1);
    chk("fetch_rsp_addr", rsp_addr, a);
    chk("fetch_rsp_inst", rsp_inst, d);
    chk("fetch_rsp_err", rsp_err, rs != 2'b00);
    tick();
    r_valid = 0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    reset = 1;
    tick();

    // Single fetch: no empty bypass, then pass-through response
    rd_valid = 1; rd_addr = 32'h8000_0000; ar_ready = 1; rsp_ready = 1;
    #1 chk("t1_no_bypass", ar_valid, 0);
    tick();
    rd_valid = 0;
    #1 chk("t1_ar_valid", ar_valid, 1);
    chk("t1_ar_addr", ar_addr, 32'h8000_0000);
    tick();
    r_valid = 1; r_data = 32'h0000_0413; r_resp = 2'b00;
    #1 chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_addr", rsp_addr, 32'h8000_0000);
    chk("t1_rsp_inst", rsp_inst, 32'h0000_0413);
    chk("t1_rsp_err", rsp_err, 0);
    tick();
    r_valid = 0;

    // Full queue refuses the fifth request; release issues at most MAX_OUT ARs
    ar_ready = 0;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1; rd_addr = 32'h8000_1000 + 32'(4 * i);
      if (i == 4) begin
        #1 chk("t2_full_ready", rd_ready, 0);
        chk("t2_full_count", count, 4);
      end
      tick();
    end
    rd_valid = 0;
    ar_ready = 1;
    repeat (4) tick();
    chk("t2_cap_count", count, 2);
    chk("t2_cap_ar_valid", ar_valid, 0);
    n = 0;
    while ((refq.size() != 0 || infl.size() != 0) && n < 30) begin
      r_valid = infl.size() > 0; r_data = $urandom; r_resp = 2'b00;
      tick(); n++;
    end
    r_valid = 0;
    chk("t2_drain_timeout", n < 30, 1);

    // Flush with two outstanding: both beats dropped, queue emptied
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1; rd_addr = 32'h8000_2000 + 32'(4 * i);
      tick();
    end
    rd_valid = 0;
    repeat (2) tick();
    flush = 1;
    tick();
    flush = 0;
    #1 chk("t3_flush_count", count, 0);
    for (int i = 0; i < 2; i++) begin
      r_valid = 1; r_data = $urandom;
      #1 chk("t3_stale_rsp_valid", rsp_valid, 0);
      chk("t3_stale_r_ready", r_ready, 1);
      tick();
    end
    r_valid = 0;
    fetch_one(32'h8000_0100, 32'h0000_0093, 2'b00);

    // Flush coincident with an R beat: only one further beat is stale
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1; rd_addr = 32'h8000_3000 + 32'(4 * i);
      tick();
    end
    rd_valid = 0;
    repeat (2) tick();
    n = n_disc;
    flush = 1; r_valid = 1; r_data = 32'h1111_1111;
    #1 chk("t4_flush_rsp_valid", rsp_valid, 0);
    tick();
    flush = 0;
    #1 chk("t4_stale_rsp_valid", rsp_valid, 0);
    tick();
    r_valid = 0;
    chk("t4_discarded", n_disc - n, 2);
    fetch_one(32'h8000_0200, 32'h0000_0513, 2'b00);

    // Error response and rsp_ready backpressure
    fetch_one(32'h8000_0300, 32'hdead_beef, 2'b10);
    rd_valid = 1; rd_addr = 32'h8000_0400;
    tick();
    rd_valid = 0;
    tick();
    rsp_ready = 0; r_valid = 1; r_data = 32'h0000_0013; r_resp = 2'b00;
    repeat (3) begin
      #1 chk("t5_hold_r_ready", r_ready, 0);
      tick();
    end
    rsp_ready = 1;
    #1 chk("t5_release_r_ready", r_ready, 1);
    chk("t5_release_rsp_addr", rsp_addr, 32'h8000_0400);
    tick();
    r_valid = 0;

    // Reset mid-transaction: 1 outstanding, 3 queued
    rd_valid = 1; rd_addr = 32'h8000_5000;
    tick();
    rd_valid = 0;
    tick();
    ar_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1; rd_addr = 32'h8000_6000 + 32'(4 * i);
      tick();
    end
    rd_valid = 0;
    chk("t6_pre_count", count, 3);
    reset = 0;
    tick();
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ar_valid", ar_valid, 0);
    reset = 1;
    #1 chk("t6_post_count", count, 0);
    chk("t6_post_rd_ready", rd_ready, 1);
    chk("t6_post_ar_valid", ar_valid, 0);
    tick();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) != 0);
      rd_valid  = $urandom_range(0, 1);
      rd_addr   = $urandom & 32'hffff_fffc;
      ar_ready  = ($urandom_range(0, 3) != 0);
      r_valid   = reset && infl.size() > 0 && ($urandom_range(0, 2) != 0);
      r_data    = $urandom;
      r_resp    = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    reset = 1; rd_valid = 0; r_valid = 0; flush = 0;
    repeat (2) tick();
    chk("rand_responses_seen", n_rsp > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030077_ifq.md
YSYX_25030077_IFQ -- requirements
Module: ysyx_25030077_ifq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning request-queue entries; it is a power of 2 and at least 1.
REQ-004 The block SHALL have parameter MAX_OUT, default 2, meaning the maximum number of ARs in flight; it is a power of 2 and at least 1.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low (0 = reset).
REQ-007 The block SHALL have ports io_rd_Req_valid (in, 1), io_rd_Req_ready (out, 1) and io_rd_Req_bits_addr (in, ADDR_W): the fetch-request enqueue port.
REQ-008 The block SHALL have ports io_ar_valid (out, 1), io_ar_ready (in, 1) and io_ar_bits_addr (out, ADDR_W): the bus read-address channel.
REQ-009 The block SHALL have ports io_r_valid (in, 1), io_r_ready (out, 1), io_r_bits_data (in, DATA_W) and io_r_bits_resp (in, 2): the bus read-data channel; responses arrive in order.
REQ-010 The block SHALL have ports io_rsp_valid (out, 1), io_rsp_ready (in, 1), io_rsp_bits_addr (out, ADDR_W), io_rsp_bits_inst (out, DATA_W) and io_rsp_bits_err (out, 1): the fetched-instruction output.
REQ-011 The block SHALL have port io_flush, input, 1 bit: discard all queued and in-flight fetches.
REQ-012 The block SHALL have port io_count, output, clog2(DEPTH)+1 bits: current request-queue occupancy.

Function
REQ-013 The request queue SHALL be a DEPTH-entry FIFO with wrapping read and write pointers, each max(1, clog2(DEPTH)) bits, and a separate occupancy count.
REQ-014 io_rd_Req_ready SHALL equal (count < DEPTH); there is no full-bypass, so a full queue refuses enqueue even while dequeuing.
REQ-015 Enqueue SHALL occur on io_rd_Req_valid && io_rd_Req_ready && !io_flush.
REQ-016 There SHALL be no empty-bypass: an address enqueued in cycle N drives io_ar_valid no earlier than cycle N+1.
REQ-017 io_ar_valid SHALL equal (count != 0) && (outstanding < MAX_OUT) && !io_flush, and io_ar_bits_addr SHALL be the queue head.
REQ-018 An AR handshake SHALL pop the queue head and push its address into an in-flight FIFO of MAX_OUT entries; outstanding increments by 1.
REQ-019 Simultaneous enqueue and pop SHALL leave count unchanged; simultaneous AR push and R completion SHALL leave outstanding unchanged.
REQ-020 A non-stale R beat SHALL pass through combinationally: io_rsp_valid = io_r_valid, io_rsp_bits_inst = io_r_bits_data, io_rsp_bits_addr = in-flight head, io_rsp_bits_err = (io_r_bits_resp != 0); io_r_ready = io_rsp_ready.
REQ-021 On an R handshake the block SHALL pop the in-flight FIFO and decrement outstanding.
REQ-022 A stale counter SHALL be kept: while stale > 0, io_r_ready = 1, io_rsp_valid = 0, and each R beat pops the in-flight FIFO and decrements stale and outstanding.
REQ-023 io_flush SHALL clear the request queue (count = 0, pointers equal) in one cycle.
REQ-024 io_flush SHALL set stale to (outstanding minus any R beat completing in that same cycle).
REQ-025 io_flush SHALL force io_rsp_valid = 0 in the flush cycle.
REQ-026 io_flush SHALL be legal in any state, including back-to-back cycles.
REQ-027 The block SHALL behave as a two-state FSM: NORMAL and DRAIN (stale > 0); flush with residual outstanding > 0 goes to DRAIN; the last stale beat returns to NORMAL; new requests may be enqueued and issued during DRAIN.
REQ-028 No response SHALL ever be produced for an address whose AR has not handshaken.

Reset
REQ-029 While reset = 0 at a clock edge, the block SHALL clear count, pointers, outstanding and stale, and set the FSM to NORMAL.
REQ-030 During reset, io_rd_Req_ready, io_ar_valid, io_r_ready and io_rsp_valid SHALL be 0 and io_count SHALL be 0.
REQ-031 Reset applied mid-transaction SHALL abandon all state, with no draining.

Structure
REQ-032 The shared package SHALL hold the FSM state enum and the RESP_OKAY = 2'b00 constant.
REQ-033 A single parametrised FIFO sub-module, ysyx_25030077_fifo (parameters WIDTH, DEPTH; with a flush input), SHALL be instantiated twice: once as the request queue and once as the in-flight address FIFO.

Verification
REQ-034 The bench SHALL cover: enqueue 0x8000_0000 with ar_ready = 1 -> ar_valid rises the next cycle with addr 0x8000_0000; r_valid with data 0x0000_0413, resp 0 -> rsp_valid with addr 0x8000_0000, inst 0x0000_0413, err 0.
REQ-035 The bench SHALL cover: ar_ready = 0 and 5 enqueues with DEPTH = 4 -> the 5th is refused (rd_Req_ready = 0, count = 4); release -> ARs issue in FIFO order, with at most MAX_OUT = 2 before an R beat.
REQ-036 The bench SHALL cover: 2 ARs outstanding, flush -> the next 2 R beats are accepted with rsp_valid = 0, and the queue is emptied; a new request 0x8000_0100 then yields a response tagged 0x8000_0100.
REQ-037 The bench SHALL cover: flush in the same cycle as an R beat with 2 outstanding -> stale = 1, and exactly one further beat is discarded.
REQ-038 The bench SHALL cover: R resp = 2'b10 -> rsp err = 1 with the correct address; rsp_ready = 0 holds r_ready = 0 until it is released.
REQ-039 The bench SHALL cover: reset asserted with 3 queued and 1 outstanding -> all outputs are at their reset values the next cycle, and count = 0.
